latch_bank_write_ctrl: RTL and testbench

Sequencing controller and round-robin arbiter for a shared bank of DW-bit D latches with enable and reset. Up to NREQ clocked requesters submit write data; the block grants one at a time and generates the latch `D`/`en`/`rst` drive with guaranteed setup, enable-width and hold phasing. All latch-side outputs come from registers, so the latch bank never sees glitches.

---
 rtl/latch_bank_write_ctrl.sv | 152 +++++++++++++++
 tb/tb_latch_bank_write_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_write_ctrl.sv
// Round-robin write arbiter and phase sequencer for a shared D-latch bank.
// Ports: clk, rst (async active-low), req/req_data/clr in; gnt, done, busy, lat_d/lat_en/lat_rst out.
module latch_bank_write_ctrl #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               clr,
    output logic [NREQ-1:0]    gnt,
    output logic               done,
    output logic               busy,
    output logic [DW-1:0]      lat_d,
    output logic               lat_en,
    output logic               lat_rst
);

    localparam int MAX_SE = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAXC   = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD,
        CLEAR
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     ptr_q;
    logic [NREQ-1:0]   gnt_q;
    logic              done_q;
    logic              busy_q;
    logic [DW-1:0]     lat_d_q;
    logic              lat_en_q;
    logic              lat_rst_q;

    logic [PW-1:0]     win_d;
    logic [PW-1:0]     ptr_d;

    // Scan from ptr downward in priority so the closest requester at or
    // after ptr is the last one written, i.e. the winner.
    always_comb begin
        win_d = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr_q) + k) % NREQ;
            if (req[idx]) begin
                win_d = PW'(idx);
            end
        end
        ptr_d = (int'(win_d) == NREQ - 1) ? '0 : win_d + PW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            lat_d_q   <= '0;
            lat_en_q  <= 1'b0;
            lat_rst_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q   <= CLEAR;
                        cnt_q     <= EN_LD;
                        busy_q    <= 1'b1;
                        lat_rst_q <= 1'b1;
                        done_q    <= (EN_CYC == 1);
                    end else if (|req) begin
                        state_q <= SETUP;
                        cnt_q   <= SETUP_LD;
                        busy_q  <= 1'b1;
                        gnt_q   <= NREQ'(1) << win_d;
                        lat_d_q <= req_data[int'(win_d)*DW +: DW];
                        ptr_q   <= ptr_d;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        state_q  <= ENABLE;
                        cnt_q    <= EN_LD;
                        lat_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ENABLE: begin
                    if (cnt_q == '0) begin
                        state_q  <= HOLD;
                        cnt_q    <= HOLD_LD;
                        lat_en_q <= 1'b0;
                        done_q   <= (HOLD_CYC == 1);
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        gnt_q   <= '0;
                        done_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - CNT_ONE;
                        done_q <= (cnt_q == CNT_ONE);
                    end
                end
                CLEAR: begin
                    if (cnt_q == '0) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        lat_rst_q <= 1'b0;
                        done_q    <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - CNT_ONE;
                        done_q <= (cnt_q == CNT_ONE);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign lat_d   = lat_d_q;
    assign lat_en  = lat_en_q;
    assign lat_rst = lat_rst_q;

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Self-checking bench for latch_bank_write_ctrl: directed vector table,
// hand sequences and random traffic against a timeline reference model.
module tb_latch_bank_write_ctrl;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int S    = 1;
    localparam int E    = 2;
    localparam int H    = 1;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic              clr;
    logic [NREQ-1:0]   gnt;
    logic              done;
    logic              busy;
    logic [DW-1:0]     lat_d;
    logic              lat_en;
    logic              lat_rst;

    int errors = 0;
    int checks = 0;

    latch_bank_write_ctrl #(
        .NREQ(NREQ), .DW(DW), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .clr(clr),
        .gnt(gnt), .done(done), .busy(busy), .lat_d(lat_d),
        .lat_en(lat_en), .lat_rst(lat_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic en,
                           input logic rs, input logic dn, input logic bz,
                           input logic [7:0] d);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".lat_en"}, 32'(lat_en), 32'(en));
        chk({tag, ".lat_rst"}, 32'(lat_rst), 32'(rs));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".busy"}, 32'(busy), 32'(bz));
        chk({tag, ".lat_d"}, 32'(lat_d), 32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a transaction is a timeline of len cycles; pos counts
    // cycles since the arbitration edge (0 means idle).
    int        m_pos, m_len, m_win, m_ptr;
    bit        m_wr;
    logic [7:0] m_d;

    task automatic model_reset();
        m_pos = 0; m_len = 0; m_win = 0; m_ptr = 0; m_wr = 0; m_d = '0;
    endtask

    task automatic model_edge();
        if (m_pos == 0) begin
            if (clr) begin
                m_wr = 0; m_len = E; m_pos = 1;
            end else if (req != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (req[i] && m_pos == 0) begin
                        m_win = i; m_pos = 1;
                    end
                end
                m_wr = 1; m_len = S + E + H;
                m_d = req_data[m_win*DW +: DW];
                m_ptr = (m_win + 1) % NREQ;
            end
        end else if (m_pos == m_len) begin
            m_pos = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic model_check(input string tag);
        logic [3:0] g;
        g = (m_pos != 0 && m_wr) ? 4'(1 << m_win) : 4'h0;
        chk_all(tag, g,
                m_wr && m_pos > S && m_pos <= S + E,
                !m_wr && m_pos != 0,
                m_pos != 0 && m_pos == m_len,
                m_pos != 0,
                m_d);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        clr;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic        en;
        logic        rs;
        logic        dn;
        logic        bz;
        logic [7:0]  d;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [3:0] r, logic c, logic [31:0] dt, logic [3:0] g,
                                logic en, logic rs, logic dn, logic bz, logic [7:0] d);
        vec_t v;
        v.req = r; v.clr = c; v.data = dt; v.gnt = g;
        v.en = en; v.rs = rs; v.dn = dn; v.bz = bz; v.d = d;
        return v;
    endfunction

    initial begin
        rst = 1'b0; req = 4'hF; clr = 1'b1; req_data = 32'h44332211;

        // Reset held with every request and clear asserted.
        tick(); tick();
        chk_all("reset_hold", 4'h0, 0, 0, 0, 0, 8'h00);
        clr = 1'b0;
        rst = 1'b1;
        tick();
        chk_all("reset_first_gnt", 4'b0001, 0, 0, 0, 1, 8'h11);

        // Round-robin with all requesters active: grants 0,1,2,3,0.
        tick(); tick(); tick(); tick();
        for (int g = 1; g < 5; g++) begin
            tick();
            chk("rr.gnt", 32'(gnt), 32'(1 << (g % 4)));
            chk("rr.lat_d", 32'(lat_d), 32'(8'h11 * (g % 4 + 1)));
            tick(); tick(); tick(); tick();
        end
        req = 4'h0;
        tick();

        // Fresh reset so the vector table starts with ptr at 0.
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        tick();

        vt.push_back(mk(4'b0001, 0, 32'h443322A5, 4'b0001, 0, 0, 0, 1, 8'hA5));
        vt.push_back(mk(4'b0000, 0, 32'h443322A5, 4'b0001, 1, 0, 0, 1, 8'hA5));
        vt.push_back(mk(4'b0000, 0, 32'h443322A5, 4'b0001, 1, 0, 0, 1, 8'hA5));
        vt.push_back(mk(4'b0000, 0, 32'h443322A5, 4'b0001, 0, 0, 1, 1, 8'hA5));
        vt.push_back(mk(4'b0000, 0, 32'h443322A5, 4'b0000, 0, 0, 0, 0, 8'hA5));
        vt.push_back(mk(4'b0010, 1, 32'h443322A5, 4'b0000, 0, 1, 0, 1, 8'hA5));
        vt.push_back(mk(4'b0010, 0, 32'h443322A5, 4'b0000, 0, 1, 1, 1, 8'hA5));
        vt.push_back(mk(4'b0010, 0, 32'h443322A5, 4'b0000, 0, 0, 0, 0, 8'hA5));
        vt.push_back(mk(4'b0010, 0, 32'h443322A5, 4'b0010, 0, 0, 0, 1, 8'h22));
        vt.push_back(mk(4'b0000, 0, 32'h443322A5, 4'b0010, 1, 0, 0, 1, 8'h22));
        vt.push_back(mk(4'b0000, 0, 32'h443322A5, 4'b0010, 1, 0, 0, 1, 8'h22));
        vt.push_back(mk(4'b0000, 0, 32'h443322A5, 4'b0010, 0, 0, 1, 1, 8'h22));
        vt.push_back(mk(4'b0000, 0, 32'h443322A5, 4'b0000, 0, 0, 0, 0, 8'h22));
        vt.push_back(mk(4'b0100, 0, 32'h443322A5, 4'b0100, 0, 0, 0, 1, 8'h33));
        vt.push_back(mk(4'b0000, 0, 32'hFFFFFFFF, 4'b0100, 1, 0, 0, 1, 8'h33));
        vt.push_back(mk(4'b0000, 0, 32'hFFFFFFFF, 4'b0100, 1, 0, 0, 1, 8'h33));
        vt.push_back(mk(4'b0000, 0, 32'hFFFFFFFF, 4'b0100, 0, 0, 1, 1, 8'h33));
        vt.push_back(mk(4'b0000, 0, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 0, 8'h33));

        foreach (vt[i]) begin
            req = vt[i].req; clr = vt[i].clr; req_data = vt[i].data;
            tick();
            chk_all($sformatf("vec%0d", i), vt[i].gnt, vt[i].en, vt[i].rs,
                    vt[i].dn, vt[i].bz, vt[i].d);
        end

        // Asynchronous reset while lat_en is high.
        req = 4'b1000; req_data = 32'h5A000000;
        tick();
        req = 4'b0000;
        tick();
        chk("async.pre_en", 32'(lat_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_all("async_mid_enable", 4'h0, 0, 0, 0, 0, 8'h00);
        #2 rst = 1'b1;
        req = 4'b0100; req_data = 32'h00770000;
        tick();
        chk_all("async_after", 4'b0100, 0, 0, 0, 1, 8'h77);
        req = 4'b0000;
        tick(); tick(); tick(); tick();

        // Random traffic against the reference model.
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = '0;
            clr = ($urandom_range(0, 9) == 0);
            req_data = $urandom;
            if ($urandom_range(0, 120) == 0) begin
                #2 rst = 1'b0;
                model_reset();
                #1;
                model_check("rand_reset");
                rst = 1'b1;
            end
            model_edge();
            tick();
            model_check("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
